// File: rtl/obj_frame_sync.sv
// Double-buffered object coordinate table: UART command words fill a shadow
// copy that is transferred to the renderer-visible registers on vsync falling edges.
module obj_frame_sync #(
  parameter int CORDW  = 10,
  parameter int NOBJ   = 4,
  parameter int ATOMIC = 0
) (
  input  logic                    pix_clk,
  input  logic                    rst_pix,
  input  logic                    n_vsync,
  input  logic                    valid_data,
  input  logic [31:0]             uart_buf,
  output logic [NOBJ*CORDW-1:0]   obj_x,
  output logic [NOBJ*CORDW-1:0]   obj_y,
  output logic [NOBJ-1:0]         obj_en,
  output logic                    commit,
  output logic [15:0]             frame_cnt,
  output logic [7:0]              err_cnt
);

  localparam logic [3:0] NOBJ_L    = 4'(NOBJ);
  localparam logic [3:0] BARRIER_L = 4'hF;

  logic                         vs_q, vs_d;
  logic [NOBJ-1:0][CORDW-1:0]   shadow_x_q, shadow_x_d;
  logic [NOBJ-1:0][CORDW-1:0]   shadow_y_q, shadow_y_d;
  logic [NOBJ-1:0]              shadow_en_q, shadow_en_d;
  logic [NOBJ-1:0]              pending_q, pending_d;
  logic                         armed_q, armed_d;
  logic [NOBJ-1:0][CORDW-1:0]   act_x_q, act_x_d;
  logic [NOBJ-1:0][CORDW-1:0]   act_y_q, act_y_d;
  logic [NOBJ-1:0]              act_en_q, act_en_d;
  logic                         commit_q, commit_d;
  logic [15:0]                  frame_cnt_q, frame_cnt_d;
  logic [7:0]                   err_cnt_q, err_cnt_d;

  logic [3:0]       w_idx_s;
  logic             w_en_s;
  logic [CORDW-1:0] w_x_s;
  logic [CORDW-1:0] w_y_s;
  logic             is_slot_s;
  logic             is_barrier_s;
  logic             is_bad_s;
  logic             vs_fall_s;
  logic             do_commit_s;

  // Word decode and frame-edge / commit qualification.
  always_comb begin
    w_idx_s      = uart_buf[31:28];
    w_en_s       = uart_buf[27];
    w_x_s        = uart_buf[2*CORDW-1:CORDW];
    w_y_s        = uart_buf[CORDW-1:0];
    is_slot_s    = valid_data && (w_idx_s < NOBJ_L);
    is_barrier_s = valid_data && (w_idx_s == BARRIER_L);
    is_bad_s     = valid_data && !(w_idx_s < NOBJ_L) && (w_idx_s != BARRIER_L);
    vs_fall_s    = vs_q && !n_vsync;
    do_commit_s  = vs_fall_s && ((ATOMIC == 0) || armed_q) && (pending_q != '0);
  end

  // Next-state: commit copies pre-edge shadow; a coinciding write lands in
  // shadow afterwards and keeps its pending bit for the following commit.
  always_comb begin
    vs_d        = n_vsync;
    shadow_x_d  = shadow_x_q;
    shadow_y_d  = shadow_y_q;
    shadow_en_d = shadow_en_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    act_en_d    = act_en_q;
    commit_d    = do_commit_s;

    if (do_commit_s) begin
      pending_d = '0;
      armed_d   = 1'b0;
    end else begin
      pending_d = pending_q;
      armed_d   = armed_q;
    end

    for (int i = 0; i < NOBJ; i++) begin
      if (do_commit_s && pending_q[i]) begin
        act_x_d[i]  = shadow_x_q[i];
        act_y_d[i]  = shadow_y_q[i];
        act_en_d[i] = shadow_en_q[i];
      end else begin
        act_x_d[i]  = act_x_q[i];
      end
      if (is_slot_s && (w_idx_s == 4'(i))) begin
        shadow_x_d[i]  = w_x_s;
        shadow_y_d[i]  = w_y_s;
        shadow_en_d[i] = w_en_s;
        pending_d[i]   = 1'b1;
      end else begin
        shadow_x_d[i]  = shadow_x_q[i];
      end
    end

    if (is_barrier_s) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_d;
    end

    if (vs_fall_s) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    if (is_bad_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge pix_clk) begin
    if (rst_pix) begin
      vs_q        <= 1'b1;
      shadow_x_q  <= '0;
      shadow_y_q  <= '0;
      shadow_en_q <= '0;
      pending_q   <= '0;
      armed_q     <= 1'b0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_en_q    <= '0;
      commit_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      vs_q        <= vs_d;
      shadow_x_q  <= shadow_x_d;
      shadow_y_q  <= shadow_y_d;
      shadow_en_q <= shadow_en_d;
      pending_q   <= pending_d;
      armed_q     <= armed_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      act_en_q    <= act_en_d;
      commit_q    <= commit_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign obj_x     = act_x_q;
  assign obj_y     = act_y_q;
  assign obj_en    = act_en_q;
  assign commit    = commit_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_obj_frame_sync.sv
// Directed bench for obj_frame_sync: one per-frame (ATOMIC=0) and one
// barrier-gated (ATOMIC=1) instance driven by the same command stream.
module tb_obj_frame_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        n_vsync;
  logic        valid;
  logic [31:0] ubuf;

  logic [39:0] x0, y0, x1, y1;
  logic [3:0]  en0, en1;
  logic        c0, c1;
  logic [15:0] fc0, fc1;
  logic [7:0]  ec0, ec1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  obj_frame_sync #(.CORDW(10), .NOBJ(4), .ATOMIC(0)) u_dut0 (
    .pix_clk(clk), .rst_pix(rst), .n_vsync(n_vsync), .valid_data(valid),
    .uart_buf(ubuf), .obj_x(x0), .obj_y(y0), .obj_en(en0), .commit(c0),
    .frame_cnt(fc0), .err_cnt(ec0));

  obj_frame_sync #(.CORDW(10), .NOBJ(4), .ATOMIC(1)) u_dut1 (
    .pix_clk(clk), .rst_pix(rst), .n_vsync(n_vsync), .valid_data(valid),
    .uart_buf(ubuf), .obj_x(x1), .obj_y(y1), .obj_en(en1), .commit(c1),
    .frame_cnt(fc1), .err_cnt(ec1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [3:0] idx, input logic en,
                                     input logic [9:0] x, input logic [9:0] y);
    return {idx, en, 7'b0, x, y};
  endfunction

  function automatic logic [39:0] pk(input logic [9:0] a3, input logic [9:0] a2,
                                     input logic [9:0] a1, input logic [9:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    valid = 1'b1;
    ubuf  = w;
    tick();
    valid = 1'b0;
    ubuf  = 32'h0;
  endtask

  task automatic fall();
    n_vsync = 1'b0;
    tick();
  endtask

  task automatic rel();
    valid   = 1'b0;
    n_vsync = 1'b1;
    tick();
  endtask

  initial begin
    logic [31:0] barrier;
    int ncommit;
    barrier = 32'hF000_0000;
    rst = 1'b1; n_vsync = 1'b1; valid = 1'b0; ubuf = 32'h0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_x0", x0, 40'h0);   chk("rst_x1", x1, 40'h0);
    chk("rst_en0", en0, 4'h0);  chk("rst_c0", c0, 1'b0);
    chk("rst_fc0", fc0, 16'h0); chk("rst_ec1", ec1, 8'h0);

    // single slot write, per-frame commit; barrier-gated copy holds off
    send(wd(4'd1, 1'b1, 10'd100, 10'd50));
    fall();
    chk("s1_x0", x0, pk(10'd0, 10'd0, 10'd100, 10'd0));
    chk("s1_y0", y0, pk(10'd0, 10'd0, 10'd50, 10'd0));
    chk("s1_en0", en0, 4'b0010);
    chk("s1_c0", c0, 1'b1);
    chk("s1_c1", c1, 1'b0);
    chk("s1_x1", x1, 40'h0);
    chk("s1_fc0", fc0, 16'd1);
    rel();
    chk("s1_c0_pulse", c0, 1'b0);

    send(wd(4'd0, 1'b1, 10'd7, 10'd0));
    fall();
    chk("s2_x0", x0, pk(10'd0, 10'd0, 10'd100, 10'd7));
    chk("s2_en0", en0, 4'b0011);
    chk("s2_c1", c1, 1'b0);
    rel();
    fall();
    chk("s3_c0_nopend", c0, 1'b0);
    chk("s3_x1", x1, 40'h0);
    chk("s3_c1", c1, 1'b0);
    rel();
    send(barrier);
    fall();
    chk("s4_x1", x1, pk(10'd0, 10'd0, 10'd100, 10'd7));
    chk("s4_en1", en1, 4'b0011);
    chk("s4_c1", c1, 1'b1);
    chk("s4_c0", c0, 1'b0);
    chk("s4_fc1", fc1, 16'd4);
    rel();

    // last write to a slot wins
    send(wd(4'd2, 1'b1, 10'd1, 10'd1));
    send(wd(4'd2, 1'b1, 10'd3, 10'd3));
    send(barrier);
    fall();
    chk("s5_x0", x0, pk(10'd0, 10'd3, 10'd100, 10'd7));
    chk("s5_x1", x1, pk(10'd0, 10'd3, 10'd100, 10'd7));
    chk("s5_en1", en1, 4'b0111);
    rel();

    // write coinciding with commit: old shadow copied, new one stays pending
    send(wd(4'd2, 1'b0, 10'd3, 10'd4));
    send(barrier);
    valid = 1'b1; ubuf = wd(4'd2, 1'b1, 10'd9, 10'd9); n_vsync = 1'b0;
    tick();
    chk("s6_x0", x0, pk(10'd0, 10'd3, 10'd100, 10'd7));
    chk("s6_y1", y1, pk(10'd0, 10'd4, 10'd50, 10'd0));
    chk("s6_en0", en0, 4'b0011);
    chk("s6_c1", c1, 1'b1);
    rel();
    fall();
    chk("s7_x0", x0, pk(10'd0, 10'd9, 10'd100, 10'd7));
    chk("s7_en0", en0, 4'b0111);
    chk("s7_x1_hold", x1, pk(10'd0, 10'd3, 10'd100, 10'd7));
    chk("s7_c1", c1, 1'b0);
    rel();

    // barrier coinciding with commit leaves the gate armed
    send(barrier);
    valid = 1'b1; ubuf = barrier; n_vsync = 1'b0;
    tick();
    chk("s8_c1", c1, 1'b1);
    chk("s8_x1", x1, pk(10'd0, 10'd9, 10'd100, 10'd7));
    chk("s8_c0", c0, 1'b0);
    rel();
    send(wd(4'd1, 1'b1, 10'd20, 10'd21));
    fall();
    chk("s9_c1_rearmed", c1, 1'b1);
    chk("s9_x1", x1, pk(10'd0, 10'd9, 10'd20, 10'd7));
    chk("s9_y0", y0, pk(10'd0, 10'd9, 10'd21, 10'd0));
    chk("s9_fc0", fc0, 16'd9);
    rel();

    // out-of-range slot indices count as errors and saturate
    for (int i = 0; i < 3; i++) send(wd(4'd4, 1'b1, 10'd1, 10'd1));
    chk("err3", ec0, 8'd3);
    send(wd(4'd14, 1'b1, 10'd1, 10'd1));
    chk("err4", ec1, 8'd4);
    for (int i = 0; i < 296; i++) send(wd(4'd5, 1'b1, 10'd1, 10'd1));
    chk("err_sat0", ec0, 8'hFF);
    chk("err_sat1", ec1, 8'hFF);
    fall();
    chk("err_c0", c0, 1'b0);
    chk("err_x0", x0, pk(10'd0, 10'd9, 10'd20, 10'd7));
    rel();

    // reset beats a pending write, a lost write and a coinciding vsync fall
    send(wd(4'd3, 1'b1, 10'd5, 10'd5));
    rst = 1'b1; valid = 1'b1; ubuf = wd(4'd0, 1'b1, 10'd8, 10'd8); n_vsync = 1'b0;
    tick();
    rst = 1'b0; valid = 1'b0;
    chk("r_fc0", fc0, 16'd0);
    chk("r_x0", x0, 40'h0);
    chk("r_ec0", ec0, 8'd0);
    tick();
    chk("r_fc_first", fc1, 16'd1);
    chk("r_c0", c0, 1'b0);
    chk("r_x1", x1, 40'h0);
    chk("r_en0", en0, 4'h0);
    rel();

    // idle frames: count advances, no commit ever
    ncommit = 0;
    for (int i = 0; i < 200; i++) begin
      fall();
      if (c0 || c1) ncommit++;
      rel();
      if (c0 || c1) ncommit++;
    end
    chk("idle_commits", 64'(ncommit), 64'd0);
    chk("idle_fc0", fc0, 16'd201);
    chk("idle_fc1", fc1, 16'd201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
